// File: rtl/issue_scoreboard_pkg.sv
// rtl/issue_scoreboard_pkg.sv - shared constants and hazard-cause type for the issue scoreboard
//
// Purpose: register-index width, the hard-wired-zero register index, and the
//          hazard-cause enum used for debug tracing of issue stalls.
// Ports:   none (package).

package issue_scoreboard_pkg;

    localparam int SB_RAW_W  = 5;
    localparam int SB_X0_IDX = 0;

    typedef enum logic [1:0] {
        HZ_NONE = 2'd0,
        HZ_RAW  = 2'd1,
        HZ_WAW  = 2'd2,
        HZ_FULL = 2'd3
    } hazard_e;

    // Single most relevant cause when several stall conditions coincide.
    function automatic hazard_e hazard_cause(input logic raw, input logic waw, input logic full);
        if (raw)  return HZ_RAW;
        if (waw)  return HZ_WAW;
        if (full) return HZ_FULL;
        return HZ_NONE;
    endfunction

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// rtl/issue_scoreboard_sb_entry.sv - pending bit and latency countdown of one architectural register
//
// Purpose: holds pend (and, with SCOREBOARD_FWD_EN defined, the result-latency
//          countdown cnt) for a single register.
//          Priority: reset > flush > set > clear > decrement.
// Ports:   clk, reset   clock and synchronous active-high reset
//          i_set        accepted writer targets this register
//          i_clr        write-back releases this register
//          i_flush      squash tracking
//          i_lat        latency loaded on set      (SCOREBOARD_FWD_EN only)
//          o_pend       registered pending bit
//          o_cnt        registered countdown       (SCOREBOARD_FWD_EN only)

module sb_entry
    import issue_scoreboard_pkg::*;
`ifdef SCOREBOARD_FWD_EN
#(
    parameter int LATW = 3
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_set,
    input  logic            i_clr,
    input  logic            i_flush,
`ifdef SCOREBOARD_FWD_EN
    input  logic [LATW-1:0] i_lat,
    output logic [LATW-1:0] o_cnt,
`endif
    output logic            o_pend
);

    logic r_pend;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_pend <= 1'b0;
        end else if (i_set) begin
            r_pend <= 1'b1;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;

`ifdef SCOREBOARD_FWD_EN
    logic [LATW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_cnt <= '0;
        end else if (i_set) begin
            r_cnt <= i_lat;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register scoreboard between ID and EX blocking RAW/WAW/capacity hazards
//
// Purpose: tracks in-flight destination registers, releases them on NWB
//          write-back channels, and gates issue on RAW, WAW and in-flight
//          capacity hazards. Defining SCOREBOARD_FWD_EN adds per-register
//          latency countdowns so a pending source whose result already sits on
//          the bypass network is forwarded instead of stalling.
// Ports:   clk, reset                          clock, synchronous active-high reset
//          issue_valid/issue_ready             instruction handshake (ready is comb)
//          issue_rs1/rs2/rd, issue_use_rs1/rs2, issue_wr_rd, issue_lat
//                                              decoded operand info
//          wb_valid/wb_rd                      write-back channels (k at [k*RAW +: RAW])
//          flush                               squash all tracking
//          stall_raw/stall_waw/stall_full      hazard causes (comb)
//          fwd_rs1/fwd_rs2                     operand from bypass (comb)
//          busy_vec, inflight_cnt              registered tracking state
//          wb_err                              sticky write-back-to-idle error

module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int RAW          = SB_RAW_W,
    parameter int NWB          = 2,
    parameter int LATW         = 3,
    parameter int MAX_INFLIGHT = 8
)
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [RAW-1:0]                   issue_rs1,
    input  logic [RAW-1:0]                   issue_rs2,
    input  logic [RAW-1:0]                   issue_rd,
    input  logic                             issue_use_rs1,
    input  logic                             issue_use_rs2,
    input  logic                             issue_wr_rd,
    input  logic [LATW-1:0]                  issue_lat,
    input  logic [NWB-1:0]                   wb_valid,
    input  logic [NWB*RAW-1:0]               wb_rd,
    input  logic                             flush,
    output logic                             stall_raw,
    output logic                             stall_waw,
    output logic                             stall_full,
    output logic                             fwd_rs1,
    output logic                             fwd_rs2,
    output logic [NREG-1:0]                  busy_vec,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
    output logic                             wb_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [NREG-1:0] w_pend;
    logic [NREG-1:0] w_wb_hit;
    logic [NREG-1:0] w_pend_eff;
    logic [NREG-1:0] w_rel;
    logic [NREG-1:1] w_set;
    logic [CW:0]     w_rel_cnt;
    logic            w_wb_bad;
    logic            w_rd_wr;
    logic            w_acc_wr;
    logic            w_raw_blk1;
    logic            w_raw_blk2;
    logic [CW-1:0]   r_inflight;
    logic            r_wb_err;
    hazard_e         w_unused_trace_cause;

    // Registers hit by any write-back this cycle; duplicates collapse to one bit,
    // so the same register on two channels is a single release.
    always_comb begin
        w_wb_hit = '0;
        w_wb_bad = 1'b0;
        for (int k = 0; k < NWB; k++) begin
            if (wb_valid[k] && (wb_rd[k*RAW +: RAW] != RAW'(SB_X0_IDX))) begin
                w_wb_hit[wb_rd[k*RAW +: RAW]] = 1'b1;
                if (!w_pend[wb_rd[k*RAW +: RAW]]) begin
                    w_wb_bad = 1'b1;
                end
            end
        end
    end

    assign w_pend_eff = w_pend & ~w_wb_hit;
    assign w_rel      = w_pend & w_wb_hit;

    always_comb begin
        w_rel_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            w_rel_cnt = w_rel_cnt + (CW+1)'(w_rel[r]);
        end
    end

`ifdef SCOREBOARD_FWD_EN
    logic [LATW-1:0] w_cnt [NREG];
    assign w_cnt[0]   = '0;
    // A pending source only blocks while its result is still further away than the bypass.
    assign w_raw_blk1 = (w_cnt[issue_rs1] != '0);
    assign w_raw_blk2 = (w_cnt[issue_rs2] != '0);
    assign fwd_rs1    = issue_use_rs1 && (issue_rs1 != RAW'(SB_X0_IDX)) &&
                        w_pend_eff[issue_rs1] && (w_cnt[issue_rs1] == '0);
    assign fwd_rs2    = issue_use_rs2 && (issue_rs2 != RAW'(SB_X0_IDX)) &&
                        w_pend_eff[issue_rs2] && (w_cnt[issue_rs2] == '0);
`else
    logic w_unused_lat;
    assign w_unused_lat = ^issue_lat;
    assign w_raw_blk1   = 1'b1;
    assign w_raw_blk2   = 1'b1;
    assign fwd_rs1      = 1'b0;
    assign fwd_rs2      = 1'b0;
`endif

    assign w_rd_wr    = issue_wr_rd && (issue_rd != RAW'(SB_X0_IDX));
    assign stall_raw  = issue_valid &&
                        ((issue_use_rs1 && w_pend_eff[issue_rs1] && w_raw_blk1) ||
                         (issue_use_rs2 && w_pend_eff[issue_rs2] && w_raw_blk2));
    assign stall_waw  = issue_valid && w_rd_wr && w_pend_eff[issue_rd];
    // Releases this cycle free capacity for a same-cycle writer.
    assign stall_full = issue_valid && w_rd_wr &&
                        (({1'b0, r_inflight} - w_rel_cnt) >= (CW+1)'(MAX_INFLIGHT));
    assign issue_ready = issue_valid && !flush && !stall_raw && !stall_waw && !stall_full;
    assign w_acc_wr    = issue_ready && w_rd_wr;

    assign w_unused_trace_cause = hazard_cause(stall_raw, stall_waw, stall_full);

    assign w_pend[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        assign w_set[r] = w_acc_wr && (issue_rd == RAW'(r));

        sb_entry
`ifdef SCOREBOARD_FWD_EN
            #(.LATW(LATW))
`endif
        u_entry (
            .clk     (clk),
            .reset   (reset),
            .i_set   (w_set[r]),
            .i_clr   (w_rel[r]),
            .i_flush (flush),
`ifdef SCOREBOARD_FWD_EN
            .i_lat   (issue_lat),
            .o_cnt   (w_cnt[r]),
`endif
            .o_pend  (w_pend[r])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= CW'({1'b0, r_inflight} + (CW+1)'(w_acc_wr) - w_rel_cnt);
        end
    end

    // Flush squashes same-cycle write-backs, so they cannot raise the error either.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_err <= 1'b0;
        end else if (w_wb_bad && !flush) begin
            r_wb_err <= 1'b1;
        end
    end

    assign busy_vec     = w_pend;
    assign inflight_cnt = r_inflight;
    assign wb_err       = r_wb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed self-checking bench for issue_scoreboard

module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_wr_rd;
    logic [2:0]  issue_lat;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic        flush;
    logic        stall_raw, stall_waw, stall_full;
    logic        fwd_rs1, fwd_rs2;
    logic [31:0] busy_vec;
    logic [3:0]  inflight_cnt;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

    issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2),
        .issue_wr_rd  (issue_wr_rd),
        .issue_lat    (issue_lat),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .stall_raw    (stall_raw),
        .stall_waw    (stall_waw),
        .stall_full   (stall_full),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .busy_vec     (busy_vec),
        .inflight_cnt (inflight_cnt),
        .wb_err       (wb_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // Advance one edge; inputs change and outputs are sampled 1-2 time units after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; issue_wr_rd = 0; issue_lat = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic writer(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        issue_valid = 1; issue_wr_rd = 1; issue_rd = rd; issue_lat = lat;
    endtask

    task automatic do_flush();
        idle(); flush = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); reset = 0; #1;
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h required %h", busy_vec, 32'h0); end
        n_vec++; if (inflight_cnt !== 4'd0) begin n_err++; $display("FAIL reset_inflight: got %0d required 0", inflight_cnt); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_wb_err: got %b required 0", wb_err); end
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", issue_ready); end
    endtask

    task automatic test_raw();
        writer(5'd5, 3'd2); #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_first_ready: got %b required 1", issue_ready); end
        tick();
        n_vec++; if (busy_vec !== 32'h20) begin n_err++; $display("FAIL raw_busy: got %h required %h", busy_vec, 32'h20); end
        n_vec++; if (inflight_cnt !== 4'd1) begin n_err++; $display("FAIL raw_inflight: got %0d required 1", inflight_cnt); end
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5'd5; #1;
        n_vec++; if (stall_raw !== 1'b1) begin n_err++; $display("FAIL raw_stall: got %b required 1", stall_raw); end
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_ready: got %b required 0", issue_ready); end
        // rs2 path on the same pending register
        issue_use_rs1 = 0; issue_use_rs2 = 1; issue_rs2 = 5'd5; #1;
        n_vec++; if (stall_raw !== 1'b1) begin n_err++; $display("FAIL raw_stall_rs2: got %b required 1", stall_raw); end
        // same-cycle write-back releases the hazard and the register
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd5}; #1;
        n_vec++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_wb_release_ready: got %b required 1", issue_ready); end
        tick(); idle();
        n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL raw_wb_release_busy: got %h required 0", busy_vec); end
        n_vec++; if (inflight_cnt !== 4'd0) begin n_err++; $display("FAIL raw_wb_release_inflight: got %0d required 0", inflight_cnt); end
    endtask

    task automatic test_fwd();
        writer(5'd5, 3'd2); tick();
        idle(); issue_valid = 1; issue_use_rs1 = 1; issue_rs1 = 5'd5; #1;
`ifdef SCOREBOARD_FWD_EN
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (stall_raw !== 1'b1 || fwd_rs1 !== 1'b0) begin n_err++; $display("FAIL fwd_wait%0d: got stall=%b fwd=%b required stall=1 fwd=0", c, stall_raw, fwd_rs1); end
            tick();
        end
        n_vec++; if (fwd_rs1 !== 1'b1 || issue_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready: got fwd=%b ready=%b required fwd=1 ready=1", fwd_rs1, issue_ready); end
        n_vec++; if (busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL fwd_busy5: got %b required 1", busy_vec[5]); end
`else
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (stall_raw !== 1'b1 || fwd_rs1 !== 1'b0 || issue_ready !== 1'b0) begin n_err++; $display("FAIL nofwd_hold%0d: got stall=%b fwd=%b ready=%b required 1 0 0", c, stall_raw, fwd_rs1, issue_ready); end
            tick();
        end
`endif
        do_flush();
    endtask

    task automatic test_waw();
        writer(5'd7, 3'd1); tick();
        writer(5'd7, 3'd1); #1;
        n_vec++; if (stall_waw !== 1'b1 || issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got waw=%b ready=%b required 1 0", stall_waw, issue_ready); end
        wb_valid = 2'b10; wb_rd = {5'd7, 5'd0}; #1;
        n_vec++; if (stall_waw !== 1'b0 || issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_wb_ready: got waw=%b ready=%b required 0 1", stall_waw, issue_ready); end
        tick(); idle();
        n_vec++; if (busy_vec !== 32'h80) begin n_err++; $display("FAIL waw_busy: got %h required %h", busy_vec, 32'h80); end
        n_vec++; if (inflight_cnt !== 4'd1) begin n_err++; $display("FAIL waw_inflight: got %0d required 1", inflight_cnt); end
        do_flush();
    endtask

    task automatic test_full();
        for (int r = 1; r <= 8; r++) begin
            writer(5'(r), 3'd1); tick();
        end
        idle();
        n_vec++; if (inflight_cnt !== 4'd8 || busy_vec !== 32'h1FE) begin n_err++; $display("FAIL full_fill: got cnt=%0d busy=%h required 8 000001fe", inflight_cnt, busy_vec); end
        writer(5'd0, 3'd1); #1;
        n_vec++; if (stall_full !== 1'b0 || issue_ready !== 1'b1) begin n_err++; $display("FAIL full_rd0: got full=%b ready=%b required 0 1", stall_full, issue_ready); end
        tick();
        writer(5'd9, 3'd1); #1;
        n_vec++; if (stall_full !== 1'b1 || issue_ready !== 1'b0) begin n_err++; $display("FAIL full_stall: got full=%b ready=%b required 1 0", stall_full, issue_ready); end
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd1}; #1;
        n_vec++; if (stall_full !== 1'b0 || issue_ready !== 1'b1) begin n_err++; $display("FAIL full_wb_ready: got full=%b ready=%b required 0 1", stall_full, issue_ready); end
        tick(); idle();
        n_vec++; if (inflight_cnt !== 4'd8 || busy_vec !== 32'h3FC) begin n_err++; $display("FAIL full_after: got cnt=%0d busy=%h required 8 000003fc", inflight_cnt, busy_vec); end
        // duplicate write-back on both channels is one release
        wb_valid = 2'b11; wb_rd = {5'd2, 5'd2}; tick(); idle();
        n_vec++; if (inflight_cnt !== 4'd7 || busy_vec !== 32'h3F8) begin n_err++; $display("FAIL full_dup_wb: got cnt=%0d busy=%h required 7 000003f8", inflight_cnt, busy_vec); end
        n_vec++; if (wb_err !== 1'b0) begin n_err++; $display("FAIL full_dup_no_err: got %b required 0", wb_err); end
        do_flush();
    endtask

    task automatic test_wb_err();
        writer(5'd6, 3'd1); tick();
        idle(); wb_valid = 2'b01; wb_rd = {5'd0, 5'd12}; tick(); idle();
        n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL wberr_set: got %b required 1", wb_err); end
        n_vec++; if (busy_vec !== 32'h40 || inflight_cnt !== 4'd1) begin n_err++; $display("FAIL wberr_state: got busy=%h cnt=%0d required 00000040 1", busy_vec, inflight_cnt); end
        do_flush();
        n_vec++; if (wb_err !== 1'b1) begin n_err++; $display("FAIL wberr_flush_hold: got %b required 1", wb_err); end
        // reset mid-operation with a writer presented
        writer(5'd10, 3'd1); tick();
        writer(5'd11, 3'd1); reset = 1; tick(); reset = 0; idle(); #1;
        n_vec++; if (wb_err !== 1'b0 || busy_vec !== 32'h0 || inflight_cnt !== 4'd0) begin n_err++; $display("FAIL wberr_reset: got err=%b busy=%h cnt=%0d required 0 0 0", wb_err, busy_vec, inflight_cnt); end
    endtask

    task automatic test_flush();
        writer(5'd3, 3'd1); tick();
        writer(5'd4, 3'd1); tick();
        n_vec++; if (busy_vec !== 32'h18 || inflight_cnt !== 4'd2) begin n_err++; $display("FAIL flush_pre: got busy=%h cnt=%0d required 00000018 2", busy_vec, inflight_cnt); end
        writer(5'd9, 3'd1); flush = 1; #1;
        n_vec++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b required 0", issue_ready); end
        tick(); idle();
        n_vec++; if (busy_vec !== 32'h0 || inflight_cnt !== 4'd0) begin n_err++; $display("FAIL flush_post: got busy=%h cnt=%0d required 0 0", busy_vec, inflight_cnt); end
        writer(5'd0, 3'd1); #1;
        n_vec++; if (issue_ready !== 1'b1 || stall_raw !== 1'b0 || stall_waw !== 1'b0 || stall_full !== 1'b0) begin n_err++; $display("FAIL rd0_ready: got ready=%b raw=%b waw=%b full=%b required 1 0 0 0", issue_ready, stall_raw, stall_waw, stall_full); end
        tick(); idle();
        n_vec++; if (busy_vec !== 32'h0 || inflight_cnt !== 4'd0) begin n_err++; $display("FAIL rd0_post: got busy=%h cnt=%0d required 0 0", busy_vec, inflight_cnt); end
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_raw();
        test_fwd();
        test_waw();
        test_full();
        test_wb_err();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Parametrised register scoreboard for the next-generation pipeline, placed between ID and EX.
- Tracks in-flight destination registers and blocks issue on RAW, WAW and capacity hazards.
- Accepts NWB write-back channels. Optionally reports when a pending operand can be taken from the bypass network instead of stalling.

Parameters:
- NREG, 32, number of architectural registers; index 0 is hard-wired zero.
- RAW, 5, register index width; must satisfy 2^RAW >= NREG.
- NWB, 2, number of write-back channels.
- LATW, 3, width of the per-register result-latency countdown.
- MAX_INFLIGHT, 8, maximum register-writing instructions outstanding.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decoded instruction presented
- issue_ready  out  1  instruction accepted this cycle (comb)
- issue_rs1, issue_rs2, issue_rd  in  RAW each  source/dest indices
- issue_use_rs1, issue_use_rs2, issue_wr_rd  in  1 each  operand/dest used
- issue_lat  in  LATW  cycles until result reaches bypass network
- wb_valid  in  NWB  per-channel write-back strobe
- wb_rd  in  NWB*RAW  per-channel dest index (channel k at [k*RAW +: RAW])
- flush  in  1  squash all in-flight tracking
- stall_raw, stall_waw, stall_full  out  1 each  hazard cause (comb)
- fwd_rs1, fwd_rs2  out  1 each  operand must come from bypass (comb)
- busy_vec  out  NREG  registered pending bits
- inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  registered outstanding count
- wb_err  out  1  sticky: write-back to non-pending register

Behaviour:
- Reset: busy_vec=0, all countdowns=0, inflight_cnt=0, wb_err=0.
- Per-register state: pend[r] and cnt[r]. pend[0] and cnt[0] are never set.
- Effective pending view:
  - pend_eff[r] = pend[r] & ~(any wb_valid[k] with wb_rd[k]==r).
  - Same-cycle write-back therefore releases a hazard combinationally.
- Hazard rules (rd=0 never hazards):
  - stall_raw = issue_valid & ((use_rs1 & pend_eff[rs1] & raw_blk(rs1)) | same for rs2).
  - raw_blk(r) = 1 without the forwarding feature; (cnt[r]!=0) with it.
  - stall_waw = issue_valid & wr_rd & rd!=0 & pend_eff[rd].
  - stall_full = issue_valid & wr_rd & rd!=0 & (inflight_cnt - wb_releases >= MAX_INFLIGHT).
  - issue_ready = issue_valid & ~flush & ~stall_raw & ~stall_waw & ~stall_full.
- Accepted issue with wr_rd & rd!=0: next cycle pend[rd]=1 and cnt[rd]=issue_lat.
- Set wins over a same-cycle clear of the same register.
- Countdown: every cycle, each cnt[r]!=0 decrements by 1. cnt is cleared when pend is cleared.
- Write-back on channel k (rd!=0):
  - If pend[rd]: clear pend[rd] and count one release.
  - Else: set wb_err. No state change; wb_err stays set until reset.
- Duplicate wb_rd on two channels in the same cycle counts as a single release.
- inflight_cnt_next = inflight_cnt + accepted_write_issue - releases. Never underflows, never exceeds MAX_INFLIGHT.
- flush: next cycle busy_vec=0, all cnt=0, inflight_cnt=0; wb_err preserved.
  - flush overrides same-cycle issue and write-back.
  - issue_ready=0 during flush.
- reset mid-operation: all state returns to reset values next edge, regardless of other inputs.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined:
  - RAW stalls only while cnt[src]!=0.
  - fwd_rs1 = use_rs1 & rs1!=0 & pend_eff[rs1] & cnt[rs1]==0; fwd_rs2 likewise.
- Undefined:
  - Any pending source stalls.
  - fwd_rs1/fwd_rs2 tied 0.
  - Countdown registers are not instantiated and issue_lat is ignored.

Decomposition:
- Shared package: register-index width constant, x0 index constant, hazard-cause enum (NONE/RAW/WAW/FULL) for debug tracing.
- One natural sub-module, sb_entry: one register's pend/cnt with set, clear, decrement and flush.
  - Instantiated NREG-1 times via generate.
  - The top holds the hazard muxing, release popcount and inflight counter.

Test Plan:
- Reset, then issue rd=5, lat=2 -> next cycle busy_vec[5]=1, inflight_cnt=1. Issue rs1=5 -> stall_raw=1, issue_ready=0.
- FWD_EN, issue rd=5, lat=2, then hold a consumer with rs1=5 -> consumer stalled for 2 cycles, then fwd_rs1=1 and issue_ready=1 while busy_vec[5] is still 1.
- Pending rd=7 with a new writer rd=7 presented -> stall_waw=1. Assert wb_valid[1]=1, wb_rd=7 in the same cycle -> issue_ready=1 and busy_vec[7] remains 1 next cycle.
- Issue 8 writers to rd 1..8 -> inflight_cnt=8. Issue a 9th -> stall_full=1. One write-back in the same cycle -> 9th accepted and inflight_cnt stays 8.
- Write-back rd=12 while not pending -> wb_err=1, busy_vec unchanged. wb_err holds through flush and clears only on reset.
- With rd 3 and 4 pending, flush together with issue rd=9 -> next cycle busy_vec=0, inflight_cnt=0, rd=9 not accepted. Issue rd=0 -> busy_vec stays 0 with no stall.
